// File: rtl/beat_rate_calc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | beat_rate_calc: peak-to-peak interval -> BPM (restoring div) -> 3 BCD.   |
// | Option BEAT_RATE_AVG_EN: average the last 4 intervals.  Rev 1.0          |
// +--------------------------------------------------------------------------+
module beat_rate_calc #(
  parameter int RATE_NUM     = 60000,
  parameter int MIN_INTERVAL = 250,
  parameter int MAX_INTERVAL = 2000,
  parameter int CNT_W        = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       peak_in,
  output logic [9:0] bpm,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       bpm_valid,
  output logic       busy,
  output logic       no_signal
);

  localparam int DVD_W = 18;
  localparam int DIV_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_INTERVAL + 1);
`ifdef BEAT_RATE_AVG_EN
  localparam logic [DVD_W-1:0] DIVIDEND = DVD_W'(4 * RATE_NUM);
`else
  localparam logic [DVD_W-1:0] DIVIDEND = DVD_W'(RATE_NUM);
`endif

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_CONVERT, S_DONE} state_t;

  state_t            state;
  logic              peak_q;
  logic              armed;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        step;
  logic [DIV_W-1:0]  divisor;
  logic [DIV_W-1:0]  rem;
  logic [DVD_W-1:0]  quo;
  logic [21:0]       dd;

  logic              peak_rise;
  logic              timeout;
  logic              accept;
  logic [CNT_W-1:0]  cnt_restart;
  logic [DIV_W-1:0]  div_in;
  logic [DIV_W:0]    trial;
  logic [DIV_W:0]    diff;
  logic              ge;
  logic [9:0]        quo_clamped;
  logic [21:0]       dd_adj;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign peak_rise   = peak_in & ~peak_q;
  assign timeout     = (state == S_IDLE) && armed && (cnt == CNT_SAT);
  assign accept      = (state == S_IDLE) && peak_rise && armed && !timeout &&
                       (cnt >= CNT_MIN) && (cnt <= CNT_MAX);
  assign cnt_restart = sample_tick ? CNT_W'(1) : '0;

  assign trial       = {rem, quo[DVD_W-1]};
  assign diff        = trial - {1'b0, divisor};
  assign ge          = (trial >= {1'b0, divisor});
  assign quo_clamped = (quo > DVD_W'(999)) ? 10'd999 : quo[9:0];
  assign dd_adj      = {dabble(dd[21:18]), dabble(dd[17:14]), dabble(dd[13:10]), dd[9:0]};

`ifdef BEAT_RATE_AVG_EN
  logic [CNT_W-1:0] ring [4];
  logic [DIV_W-1:0] sum;
  logic [1:0]       ring_ptr;
  logic             ring_full;

  // First accepted interval seeds every slot, so the sum starts at 4x.
  assign div_in = ring_full ? (sum + {1'b0, cnt} - {1'b0, ring[ring_ptr]})
                            : {cnt[CNT_W-2:0], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || timeout) begin
      for (int i = 0; i < 4; i++) ring[i] <= '0;
      sum       <= '0;
      ring_ptr  <= '0;
      ring_full <= 1'b0;
    end else if (accept) begin
      if (!ring_full) begin
        for (int i = 0; i < 4; i++) ring[i] <= cnt;
      end else begin
        ring[ring_ptr] <= cnt;
        ring_ptr       <= ring_ptr + 2'd1;
      end
      sum       <= div_in;
      ring_full <= 1'b1;
    end
  end
`else
  assign div_in = {1'b0, cnt};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      peak_q    <= 1'b0;
      armed     <= 1'b0;
      cnt       <= '0;
      step      <= '0;
      divisor   <= '0;
      rem       <= '0;
      quo       <= '0;
      dd        <= '0;
      bpm       <= '0;
      bcd2      <= '0;
      bcd1      <= '0;
      bcd0      <= '0;
      bpm_valid <= 1'b0;
      busy      <= 1'b0;
      no_signal <= 1'b1;
    end else begin
      peak_q    <= peak_in;
      bpm_valid <= 1'b0;

      // A timeout coinciding with an edge lets that edge re-arm only.
      if ((state == S_IDLE) && peak_rise && (timeout || !armed || accept))
        cnt <= cnt_restart;
      else if (sample_tick && (cnt != CNT_SAT))
        cnt <= cnt + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (timeout) begin
            armed     <= peak_rise;
            bpm       <= '0;
            bcd2      <= '0;
            bcd1      <= '0;
            bcd0      <= '0;
            bpm_valid <= 1'b1;
            no_signal <= 1'b1;
          end else if (peak_rise && !armed) begin
            armed <= 1'b1;
          end else if (accept) begin
            divisor <= div_in;
            rem     <= '0;
            quo     <= DIVIDEND;
            step    <= '0;
            busy    <= 1'b1;
            state   <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem  <= ge ? diff[DIV_W-1:0] : trial[DIV_W-1:0];
          quo  <= {quo[DVD_W-2:0], ge};
          step <= step + 5'd1;
          if (step == 5'd17) begin
            step  <= '0;
            state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (step == 5'd0) dd <= {12'd0, quo_clamped};
          else              dd <= dd_adj << 1;
          step <= step + 5'd1;
          if (step == 5'd10) state <= S_DONE;
        end
        S_DONE: begin
          bpm       <= quo_clamped;
          bcd2      <= dd[21:18];
          bcd1      <= dd[17:14];
          bcd0      <= dd[13:10];
          bpm_valid <= 1'b1;
          no_signal <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_beat_rate_calc.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for beat_rate_calc; avg vectors run when BEAT_RATE_AVG_EN is defined.
module tb_beat_rate_calc;

  localparam int TICK_GAP = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       peak_in;
  logic [9:0] bpm;
  logic [3:0] bcd2, bcd1, bcd0;
  logic       bpm_valid, busy, no_signal;

  int n_cmp  = 0;
  int n_fail = 0;
  int tick_count = 0;
  int phase = 0;

  int         lat;
  int         pulses;
  logic [9:0] r_bpm;
  logic [11:0] r_bcd;
  logic       r_ns;
  logic       r_busy0;

  beat_rate_calc dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .peak_in(peak_in),
    .bpm(bpm), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .bpm_valid(bpm_valid), .busy(busy), .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    sample_tick = (phase == 0);
    if (phase == 0) tick_count++;
    phase = (phase + 1) % TICK_GAP;
  endtask

  task automatic advance_until(input int target);
    while (tick_count < target) step();
  endtask

  // Raise peak_in away from a tick; k = number of posedges since the edge was registered.
  task automatic peak_watch(input int kreset, output int edge_tk);
    while (phase == 0) step();
    step();
    peak_in = 1'b1;
    edge_tk = tick_count;
    lat = -1; pulses = 0; r_bpm = 'x; r_bcd = 'x; r_ns = 1'bx; r_busy0 = 1'bx;
    for (int k = 0; k <= 40; k++) begin
      step();
      if (k == 0) r_busy0 = busy;
      if (bpm_valid === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = k; r_bpm = bpm; r_bcd = {bcd2, bcd1, bcd0}; r_ns = no_signal;
        end
      end
      if (k == 3) peak_in = 1'b0;
      if (k == kreset) reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; sample_tick = 1'b0; peak_in = 1'b0;
    repeat (5) step();
    n_cmp++;
    if ({bpm, bcd2, bcd1, bcd0} !== 22'd0) begin
      $display("FAIL reset_outputs: got %h want 0", {bpm, bcd2, bcd1, bcd0}); n_fail++;
    end
    n_cmp++;
    if ({bpm_valid, busy, no_signal} !== 3'b001) begin
      $display("FAIL reset_flags: got %b want 001", {bpm_valid, busy, no_signal}); n_fail++;
    end
    reset = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_rate_60(output int base);
    int a;
    peak_watch(-1, a);
    n_cmp++;
    if (pulses !== 0) begin $display("FAIL arm_only: got %0d pulses want 0", pulses); n_fail++; end
    n_cmp++;
    if (no_signal !== 1'b1) begin $display("FAIL arm_no_signal: got %b want 1", no_signal); n_fail++; end
    advance_until(a + 1000);
    peak_watch(-1, base);
    n_cmp++;
    if (lat !== 30 || pulses !== 1) begin
      $display("FAIL lat_60: got lat %0d pulses %0d want 30/1", lat, pulses); n_fail++;
    end
    n_cmp++;
    if (r_bpm !== 10'd60 || r_bcd !== 12'h060) begin
      $display("FAIL bpm_60: got %0d bcd %h want 60 bcd 060", r_bpm, r_bcd); n_fail++;
    end
    n_cmp++;
    if (r_ns !== 1'b0 || r_busy0 !== 1'b1) begin
      $display("FAIL flags_60: got no_signal %b busy %b want 0/1", r_ns, r_busy0); n_fail++;
    end
  endtask

  task automatic test_rate_100_240(inout int base);
    advance_until(base + 600);
    peak_watch(-1, base);
    n_cmp++;
    if (lat !== 30 || r_bpm !== 10'd100 || r_bcd !== 12'h100) begin
      $display("FAIL bpm_100: got lat %0d bpm %0d bcd %h want 30 100 100", lat, r_bpm, r_bcd); n_fail++;
    end
    advance_until(base + 250);
    peak_watch(-1, base);
    n_cmp++;
    if (lat !== 30 || r_bpm !== 10'd240 || r_bcd !== 12'h240) begin
      $display("FAIL bpm_240: got lat %0d bpm %0d bcd %h want 30 240 240", lat, r_bpm, r_bcd); n_fail++;
    end
  endtask

  task automatic test_reset_mid(inout int base);
    int a;
    advance_until(base + 250);
    peak_watch(10, a);
    n_cmp++;
    if (pulses !== 0) begin $display("FAIL reset_abort: got %0d pulses want 0", pulses); n_fail++; end
    n_cmp++;
    if ({bpm, bcd2, bcd1, bcd0, bpm_valid, busy, no_signal} !== 25'd1) begin
      $display("FAIL reset_mid_state: got %h want 1", {bpm, bcd2, bcd1, bcd0, bpm_valid, busy, no_signal});
      n_fail++;
    end
    reset = 1'b1;
    repeat (3) step();
    peak_watch(-1, a);
    n_cmp++;
    if (pulses !== 0) begin $display("FAIL rearm_after_reset: got %0d pulses want 0", pulses); n_fail++; end
    advance_until(a + 300);
    peak_watch(-1, base);
    n_cmp++;
    if (lat !== 30 || r_bpm !== 10'd200 || r_bcd !== 12'h200) begin
      $display("FAIL bpm_200: got lat %0d bpm %0d bcd %h want 30 200 200", lat, r_bpm, r_bcd); n_fail++;
    end
  endtask

  task automatic test_spurious(inout int base);
    int a;
    advance_until(base + 100);
    peak_watch(-1, a);
    n_cmp++;
    if (pulses !== 0) begin $display("FAIL spurious_ignored: got %0d pulses want 0", pulses); n_fail++; end
    advance_until(base + 1000);
    peak_watch(-1, base);
    n_cmp++;
    if (lat !== 30 || r_bpm !== 10'd60 || r_bcd !== 12'h060) begin
      $display("FAIL spurious_result: got lat %0d bpm %0d bcd %h want 30 60 060", lat, r_bpm, r_bcd); n_fail++;
    end
  endtask

  task automatic test_timeout(input int base);
    int seen_tick;
    int a;
    seen_tick = -1;
    advance_until(base + 2000);
    for (int k = 0; k < 3 * TICK_GAP; k++) begin
      step();
      if (bpm_valid === 1'b1 && seen_tick < 0) begin
        seen_tick = tick_count - base;
        r_bpm = bpm; r_bcd = {bcd2, bcd1, bcd0}; r_ns = no_signal;
      end
    end
    n_cmp++;
    if (seen_tick !== 2001) begin
      $display("FAIL timeout_point: got tick %0d want 2001", seen_tick); n_fail++;
    end
    n_cmp++;
    if (r_bpm !== 10'd0 || r_bcd !== 12'h000 || r_ns !== 1'b1) begin
      $display("FAIL timeout_values: got bpm %0d bcd %h ns %b want 0 000 1", r_bpm, r_bcd, r_ns); n_fail++;
    end
    peak_watch(-1, a);
    n_cmp++;
    if (pulses !== 0 || no_signal !== 1'b1) begin
      $display("FAIL timeout_rearm: got pulses %0d ns %b want 0 1", pulses, no_signal); n_fail++;
    end
  endtask

  task automatic test_avg();
    int iv   [4] = '{1000, 1000, 500, 500};
    int exp_b[4] = '{60, 60, 68, 80};
    logic [11:0] exp_d [4] = '{12'h060, 12'h060, 12'h068, 12'h080};
    int base;
    peak_watch(-1, base);
    for (int i = 0; i < 4; i++) begin
      advance_until(base + iv[i]);
      peak_watch(-1, base);
      n_cmp++;
      if (lat !== 30 || r_bpm !== 10'(exp_b[i]) || r_bcd !== exp_d[i]) begin
        $display("FAIL avg_%0d: got lat %0d bpm %0d bcd %h want 30 %0d %h",
                 i, lat, r_bpm, r_bcd, exp_b[i], exp_d[i]);
        n_fail++;
      end
    end
  endtask

  initial begin
    int base;
    test_reset();
`ifdef BEAT_RATE_AVG_EN
    test_avg();
`else
    test_rate_60(base);
    test_rate_100_240(base);
    test_reset_mid(base);
    test_spurious(base);
    test_timeout(base);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
